// File: rtl/traffic_phase_ctrl_pkg.sv
// Shared types and constants for the intersection phase sequencer.
// Holds the state encodings, the phase-select and lamp codes, and the
// state-to-output decode used by the sequencer.
package traffic_phase_ctrl_pkg;

    localparam int unsigned STATE_W = 4;
    localparam int unsigned SEL_W   = 3;
    localparam int unsigned LAMP_W  = 3;

    typedef enum logic [STATE_W-1:0] {
        ALL_RED_B = 4'd0,
        MAIN_G    = 4'd1,
        MAIN_Y    = 4'd2,
        ALL_RED_A = 4'd3,
        SIDE_G    = 4'd4,
        SIDE_Y    = 4'd5,
        PED_WALK  = 4'd6,
        PED_CLEAR = 4'd7,
        FLASH     = 4'd8
    } state_t;

    // One-hot phase length request to the phase timer
    localparam logic [SEL_W-1:0] SEL_LONG  = 3'b001;
    localparam logic [SEL_W-1:0] SEL_SHORT = 3'b010;
    localparam logic [SEL_W-1:0] SEL_MED   = 3'b100;

    // Lamp triplets, {red,yellow,green}
    localparam logic [LAMP_W-1:0] RED = 3'b100;
    localparam logic [LAMP_W-1:0] YEL = 3'b010;
    localparam logic [LAMP_W-1:0] GRN = 3'b001;
    localparam logic [LAMP_W-1:0] OFF = 3'b000;

    typedef struct packed {
        logic [LAMP_W-1:0] main_lights;
        logic [LAMP_W-1:0] side_lights;
        logic              walk;
        logic [SEL_W-1:0]  phase_sel;
    } lamp_out_t;

    localparam lamp_out_t RESET_OUT = '{main_lights: RED, side_lights: RED,
                                        walk: 1'b0, phase_sel: SEL_MED};

    // Lamp/walk/phase-select pattern shown while in a given state
    function automatic lamp_out_t outputs_for(input state_t st, input logic flash_phase);
        lamp_out_t o;
        o = RESET_OUT;
        case (st)
            ALL_RED_B: o = '{main_lights: RED, side_lights: RED, walk: 1'b0, phase_sel: SEL_MED};
            MAIN_G:    o = '{main_lights: GRN, side_lights: RED, walk: 1'b0, phase_sel: SEL_LONG};
            MAIN_Y:    o = '{main_lights: YEL, side_lights: RED, walk: 1'b0, phase_sel: SEL_SHORT};
            ALL_RED_A: o = '{main_lights: RED, side_lights: RED, walk: 1'b0, phase_sel: SEL_MED};
            SIDE_G:    o = '{main_lights: RED, side_lights: GRN, walk: 1'b0, phase_sel: SEL_LONG};
            SIDE_Y:    o = '{main_lights: RED, side_lights: YEL, walk: 1'b0, phase_sel: SEL_SHORT};
            PED_WALK:  o = '{main_lights: RED, side_lights: RED, walk: 1'b1, phase_sel: SEL_LONG};
            PED_CLEAR: o = '{main_lights: RED, side_lights: RED, walk: 1'b0, phase_sel: SEL_SHORT};
            FLASH:     o = '{main_lights: {1'b0, flash_phase, 1'b0},
                             side_lights: {flash_phase, 2'b00},
                             walk: 1'b0, phase_sel: SEL_SHORT};
            default:   o = RESET_OUT;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/traffic_phase_ctrl_ped_req_latch.sv
// Pedestrian request latch.
// Ports:
//   clk, rst  - clock, asynchronous active-low reset
//   req       - pedestrian request (already gated by the enable)
//   serve     - the sequencer is entering the walk phase on this edge
//   pending   - a request is waiting to be served
//   ack       - one-cycle pulse in the cycle after the serving edge
module traffic_phase_ctrl_ped_req_latch (
    input  logic clk,
    input  logic rst,
    input  logic req,
    input  logic serve,
    output logic pending,
    output logic ack
);

    // Serve wins over a coincident request so it is absorbed by this walk
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending <= 1'b0;
            ack     <= 1'b0;
        end else begin
            if (serve) begin
                pending <= 1'b0;
            end else if (req) begin
                pending <= 1'b1;
            end
            ack <= serve;
        end
    end

endmodule

// File: rtl/traffic_phase_ctrl.sv
// Intersection phase sequencer. Advances on the phase timer's done pulse and
// drives the one-hot phase length back to the timer; lamps change on the same
// edge as the state so the timer sees no extra latency.
// Ports:
//   clk, rst     - clock, asynchronous active-low reset
//   phase_done   - one-cycle pulse: current phase has expired
//   side_car     - side-road vehicle present
//   ped_req      - pedestrian button
//   flash_en     - night flash mode request
//   phase_sel    - one-hot phase length to the timer
//   main_lights  - main road {red,yellow,green}
//   side_lights  - side road {red,yellow,green}
//   walk         - pedestrian walk lamp
//   ped_ack      - one-cycle pulse when a pedestrian request is served
//   state_dbg    - current state encoding
module traffic_phase_ctrl
    import traffic_phase_ctrl_pkg::*;
#(
    parameter bit PED_ENABLE = 1'b1,
    parameter bit SIDE_SENSE = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              phase_done,
    input  logic              side_car,
    input  logic              ped_req,
    input  logic              flash_en,
    output logic [SEL_W-1:0]  phase_sel,
    output logic [LAMP_W-1:0] main_lights,
    output logic [LAMP_W-1:0] side_lights,
    output logic              walk,
    output logic              ped_ack,
    output logic [STATE_W-1:0] state_dbg
);

    state_t    state, state_nxt;
    logic      flash_phase, flash_phase_nxt;
    lamp_out_t out_q, out_nxt;

    logic side_demand;
    logic ped_req_gated;
    logic ped_pending;
    logic ped_serve;

    assign side_demand   = SIDE_SENSE ? side_car : 1'b1;
    assign ped_req_gated = PED_ENABLE ? ped_req : 1'b0;
    assign ped_serve     = phase_done && (state == SIDE_Y) && ped_pending;

    traffic_phase_ctrl_ped_req_latch u_ped_latch (
        .clk     (clk),
        .rst     (rst),
        .req     (ped_req_gated),
        .serve   (ped_serve),
        .pending (ped_pending),
        .ack     (ped_ack)
    );

    // State, flash toggle and registered lamp pattern
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ALL_RED_B;
            flash_phase <= 1'b0;
            out_q       <= RESET_OUT;
        end else begin
            state       <= state_nxt;
            flash_phase <= flash_phase_nxt;
            out_q       <= out_nxt;
        end
    end

    // Next state; flash mode is only honoured at the all-red phases
    always_comb begin
        state_nxt       = state;
        flash_phase_nxt = flash_phase;
        if (phase_done) begin
            case (state)
                ALL_RED_B, ALL_RED_A: begin
                    if (flash_en) begin
                        state_nxt       = FLASH;
                        flash_phase_nxt = 1'b1;
                    end else begin
                        state_nxt = (state == ALL_RED_B) ? MAIN_G : SIDE_G;
                    end
                end
                MAIN_G: begin
                    if (side_demand || ped_pending || flash_en) begin
                        state_nxt = MAIN_Y;
                    end
                end
                MAIN_Y:    state_nxt = ALL_RED_A;
                SIDE_G:    state_nxt = SIDE_Y;
                SIDE_Y:    state_nxt = ped_pending ? PED_WALK : ALL_RED_B;
                PED_WALK:  state_nxt = PED_CLEAR;
                PED_CLEAR: state_nxt = ALL_RED_B;
                FLASH: begin
                    if (flash_en) begin
                        flash_phase_nxt = ~flash_phase;
                    end else begin
                        state_nxt       = ALL_RED_B;
                        flash_phase_nxt = 1'b0;
                    end
                end
                default: begin
                    state_nxt       = ALL_RED_B;
                    flash_phase_nxt = 1'b0;
                end
            endcase
        end
        out_nxt = outputs_for(state_nxt, flash_phase_nxt);
    end

    assign phase_sel   = out_q.phase_sel;
    assign main_lights = out_q.main_lights;
    assign side_lights = out_q.side_lights;
    assign walk        = out_q.walk;
    assign state_dbg   = state;

    // Conflicting movements must never be released together
    a_no_conflict: assert property (@(posedge clk) disable iff (!rst)
        !((main_lights[1:0] != 2'b00) && (side_lights[1:0] != 2'b00)));
    a_walk_all_red: assert property (@(posedge clk) disable iff (!rst)
        walk |-> ((main_lights == RED) && (side_lights == RED)));
    a_sel_onehot: assert property (@(posedge clk) disable iff (!rst)
        $onehot(phase_sel));

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Scoreboard bench for the intersection phase sequencer with a simple
// phase timer model (long=6, short=3, medium=5 clocks).
module tb_traffic_phase_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       phase_done;
    logic       side_car;
    logic       ped_req;
    logic       flash_en;
    logic [2:0] phase_sel;
    logic [2:0] main_lights;
    logic [2:0] side_lights;
    logic       walk;
    logic       ped_ack;
    logic [3:0] state_dbg;

    localparam logic [3:0] S_ARB = 4'd0, S_MG = 4'd1, S_MY = 4'd2, S_ARA = 4'd3,
                           S_SG = 4'd4, S_SY = 4'd5, S_PW = 4'd6, S_PC = 4'd7,
                           S_FL = 4'd8;

    // {state, main, side, walk, phase_sel, ped_ack}
    typedef logic [14:0] exp_t;

    exp_t        sb_q[$];
    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    logic        ack_followup = 1'b0;

    traffic_phase_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .phase_done  (phase_done),
        .side_car    (side_car),
        .ped_req     (ped_req),
        .flash_en    (flash_en),
        .phase_sel   (phase_sel),
        .main_lights (main_lights),
        .side_lights (side_lights),
        .walk        (walk),
        .ped_ack     (ped_ack),
        .state_dbg   (state_dbg)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input exp_t obs, input exp_t exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Expected outputs for a state, from the published state table
    function automatic exp_t model(input logic [3:0] st, input logic fp);
        logic [2:0] m, s, sel;
        logic       w;
        w = 1'b0;
        case (st)
            S_MG:    begin m = 3'b001; s = 3'b100; sel = 3'b001; end
            S_MY:    begin m = 3'b010; s = 3'b100; sel = 3'b010; end
            S_SG:    begin m = 3'b100; s = 3'b001; sel = 3'b001; end
            S_SY:    begin m = 3'b100; s = 3'b010; sel = 3'b010; end
            S_PW:    begin m = 3'b100; s = 3'b100; sel = 3'b001; w = 1'b1; end
            S_PC:    begin m = 3'b100; s = 3'b100; sel = 3'b010; end
            S_FL:    begin m = {1'b0, fp, 1'b0}; s = {fp, 2'b00}; sel = 3'b010; end
            default: begin m = 3'b100; s = 3'b100; sel = 3'b100; end
        endcase
        return {st, m, s, w, sel, (st == S_PW)};
    endfunction

    function automatic exp_t observed();
        return {state_dbg, main_lights, side_lights, walk, phase_sel, ped_ack};
    endfunction

    // Runs the current phase to expiry; ped_mode 1 = ped pulse in first
    // cycle of the phase, 2 = ped pulse coincident with phase_done
    task automatic step(input string tag, input logic [3:0] st, input logic fp,
                        input int ped_mode);
        int   n;
        exp_t e;
        case (phase_sel)
            3'b001:  n = 6;
            3'b010:  n = 3;
            default: n = 5;
        endcase
        sb_q.push_back(model(st, fp));
        ped_req = (ped_mode == 1);
        for (int i = 0; i < n - 1; i++) begin
            @(negedge clk);
            ped_req = 1'b0;
            if (ack_followup) begin
                check_val({tag, "_ackdrop"}, exp_t'(ped_ack), exp_t'(0));
                ack_followup = 1'b0;
            end
        end
        phase_done = 1'b1;
        if (ped_mode == 2) ped_req = 1'b1;
        @(negedge clk);
        phase_done = 1'b0;
        ped_req    = 1'b0;
        e = sb_q.pop_front();
        check_val(tag, observed(), e);
        if (st == S_PW) ack_followup = 1'b1;
    endtask

    initial begin
        rst        = 1'b0;
        phase_done = 1'b0;
        side_car   = 1'b0;
        ped_req    = 1'b0;
        flash_en   = 1'b0;
        repeat (2) @(negedge clk);
        check_val("reset", observed(), model(S_ARB, 1'b0));
        rst = 1'b1;

        // No demand: main green re-arms
        step("first_mg", S_MG, 1'b0, 0);
        for (int i = 0; i < 3; i++) step("dwell_mg", S_MG, 1'b0, 0);

        // Side demand: full cycle
        side_car = 1'b1;
        step("cyc_my",  S_MY,  1'b0, 0);
        step("cyc_ara", S_ARA, 1'b0, 0);
        step("cyc_sg",  S_SG,  1'b0, 0);
        step("cyc_sy",  S_SY,  1'b0, 0);
        step("cyc_arb", S_ARB, 1'b0, 0);
        step("cyc_mg",  S_MG,  1'b0, 0);

        // Ped request during side green, another during walk
        step("ped_my",  S_MY,  1'b0, 0);
        step("ped_ara", S_ARA, 1'b0, 0);
        step("ped_sg",  S_SG,  1'b0, 0);
        step("ped_sy",  S_SY,  1'b0, 1);
        step("ped_pw",  S_PW,  1'b0, 0);
        step("ped_pc",  S_PC,  1'b0, 1);
        step("ped_arb", S_ARB, 1'b0, 0);
        step("ped_mg",  S_MG,  1'b0, 0);
        side_car = 1'b0;
        step("ped2_my",  S_MY,  1'b0, 0);
        step("ped2_ara", S_ARA, 1'b0, 0);
        step("ped2_sg",  S_SG,  1'b0, 0);
        step("ped2_sy",  S_SY,  1'b0, 0);
        step("ped2_pw",  S_PW,  1'b0, 2);
        step("ped2_pc",  S_PC,  1'b0, 0);
        step("ped2_arb", S_ARB, 1'b0, 0);
        step("ped2_mg",  S_MG,  1'b0, 0);
        step("absorbed", S_MG,  1'b0, 0);

        // Night flash entered via yellow and all-red
        flash_en = 1'b1;
        step("fl_my",  S_MY,  1'b0, 0);
        step("fl_ara", S_ARA, 1'b0, 0);
        step("fl_on",  S_FL,  1'b1, 0);
        step("fl_off", S_FL,  1'b0, 0);
        step("fl_on2", S_FL,  1'b1, 0);
        flash_en = 1'b0;
        step("fl_arb", S_ARB, 1'b0, 0);
        step("fl_mg",  S_MG,  1'b0, 0);

        // Reset mid-cycle with a pending ped request
        side_car = 1'b1;
        step("rs_my",  S_MY,  1'b0, 0);
        step("rs_ara", S_ARA, 1'b0, 0);
        step("rs_sg",  S_SG,  1'b0, 0);
        ped_req = 1'b1;
        @(negedge clk);
        ped_req = 1'b0;
        rst     = 1'b0;
        #2;
        check_val("async_rst", observed(), model(S_ARB, 1'b0));
        @(negedge clk);
        phase_done = 1'b1;
        @(negedge clk);
        phase_done = 1'b0;
        check_val("done_in_rst", observed(), model(S_ARB, 1'b0));
        rst = 1'b1;
        step("post_mg",  S_MG,  1'b0, 0);
        step("post_my",  S_MY,  1'b0, 0);
        step("post_ara", S_ARA, 1'b0, 0);
        step("post_sg",  S_SG,  1'b0, 0);
        step("post_sy",  S_SY,  1'b0, 0);
        step("no_walk",  S_ARB, 1'b0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
